// File: rtl/irq_priority_ctrl.sv
// Edge-latched, masked, fixed-priority interrupt controller (line 0 highest); IRQ_NESTING_EN allows preemption by higher-priority lines.
// Latency: irqIn rise -> pending at edge t -> intReq after edge t+1; intReq/intId/intVector hold until intTaken.
module irq_priority_ctrl #(
   parameter int unsigned         NUM_IRQ    = 8,
   parameter int unsigned         PC_WIDTH   = 32,
   parameter logic [PC_WIDTH-1:0] VEC_BASE   = PC_WIDTH'(32'h0000_0010),
   parameter int unsigned         VEC_STRIDE = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_IRQ-1:0]  irqIn,
   input  logic                maskWr,
   input  logic [NUM_IRQ-1:0]  maskData,
   input  logic                intTaken,
   input  logic                retiDone,
   output logic                intReq,
   output logic [PC_WIDTH-1:0] intVector,
   output logic [3:0]          intId,
   output logic [NUM_IRQ-1:0]  inService,
   output logic [NUM_IRQ-1:0]  pendingOut
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t              state;
   logic [NUM_IRQ-1:0]  irqPrev;
   logic [NUM_IRQ-1:0]  pending;
   logic [NUM_IRQ-1:0]  mask;
   logic                primed;
   logic [NUM_IRQ-1:0]  rising;
   logic [NUM_IRQ-1:0]  ready;
   logic [NUM_IRQ-1:0]  idOneHot;
   logic [NUM_IRQ-1:0]  takeMask;
   logic [NUM_IRQ-1:0]  svcRetired;
   logic [3:0]          candId;
   logic                candValid;
   logic                eligible;
   logic [PC_WIDTH-1:0] candVector;

   // The first edge after reset only loads history, so lines already high stay quiet.
   assign rising     = irqIn & ~irqPrev & {NUM_IRQ{primed}};
   assign ready      = pending & mask;
   assign pendingOut = pending;
   assign idOneHot   = {{(NUM_IRQ-1){1'b0}}, 1'b1} << intId;
   assign takeMask   = (state == REQ && intTaken) ? idOneHot : '0;
   assign svcRetired = inService & (inService - NUM_IRQ'(1));
   assign candVector = VEC_BASE + PC_WIDTH'(candId) * PC_WIDTH'(VEC_STRIDE);

   always_comb begin
      candValid = 1'b0;
      candId    = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (ready[i]) begin
            candValid = 1'b1;
            candId    = 4'(i);
         end
      end
   end

`ifdef IRQ_NESTING_EN
   logic [4:0] svcLowId;

   always_comb begin
      svcLowId = 5'(NUM_IRQ);
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (inService[i]) svcLowId = 5'(i);
      end
      eligible = candValid && ({1'b0, candId} < svcLowId);
   end
`else
   always_comb begin
      eligible = candValid && (inService == '0);
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         intReq    <= 1'b0;
         intId     <= '0;
         intVector <= VEC_BASE;
         inService <= '0;
         pending   <= '0;
         mask      <= '1;
         irqPrev   <= '0;
         primed    <= 1'b0;
      end else begin
         primed  <= 1'b1;
         irqPrev <= irqIn;
         if (maskWr) mask <= maskData;
         // A new edge on the line being taken wins over its clear.
         pending <= (pending & ~takeMask) | rising;

         case (state)
            IDLE: begin
               if (eligible) begin
                  state     <= REQ;
                  intReq    <= 1'b1;
                  intId     <= candId;
                  intVector <= candVector;
               end
            end
            REQ: begin
               if (intTaken) begin
                  state     <= SERVICE;
                  intReq    <= 1'b0;
                  inService <= inService | idOneHot;
               end
            end
            SERVICE: begin
               if (retiDone) begin
                  inService <= svcRetired;
                  if (svcRetired == '0) state <= IDLE;
               end else if (eligible) begin
                  state     <= REQ;
                  intReq    <= 1'b1;
                  intId     <= candId;
                  intVector <= candVector;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
